// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: requests words from instruction memory, queues them
// in a small FIFO and hands them to decode. Taken jmp/jb redirect the PC and flush.
//
//   state | meaning
//   IDLE  | no memory request outstanding
//   WAIT  | request outstanding, returned word will be kept
//   DROP  | request outstanding, returned word is stale and discarded
module instr_fetch_unit #(
    parameter int unsigned    AW       = 16,
    parameter int unsigned    DEPTH    = 2,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_instr,
    output logic [5:0]    id_opcode,
    output logic [AW-1:0] id_pc,
    input  logic [1:0]    j,
    input  logic          br_cond,
    output logic          redirect
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] req_addr;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_instr [DEPTH];
    logic [AW-1:0] buf_pc    [DEPTH];

    logic          transfer;
    logic          jump_taken;
    logic [AW-1:0] target;
    logic          pop;
    logic          push;
    logic [CW-1:0] count_after_pop;
    logic [CW-1:0] count_next;

    // Handshake decode, jump resolution and FIFO occupancy arithmetic
    always_comb begin
        transfer        = id_valid & id_ready;
        jump_taken      = transfer & ((j == 2'b10) | ((j == 2'b11) & br_cond));
        target          = AW'(id_instr[15:0]);
        pop             = transfer & ~jump_taken;
        push            = (state == WAIT) & imem_ack & ~jump_taken;
        count_after_pop = count - {{(CW-1){1'b0}}, pop};
        count_next      = count_after_pop + {{(CW-1){1'b0}}, push};
    end

    // Fetch FSM: PC sequencing, request address and outstanding-request tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (jump_taken) begin
                        pc <= target;
                    end else if (count < DEPTH_C) begin
                        req_addr <= pc;
                        pc       <= pc + 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (jump_taken) begin
                        pc    <= target;
                        // a word arriving with the jump is stale; otherwise wait it out
                        state <= imem_ack ? IDLE : DROP;
                    end else if (imem_ack) begin
                        if (count_next < DEPTH_C) begin
                            req_addr <= pc;
                            pc       <= pc + 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (jump_taken) begin
                        pc <= target;
                    end
                    if (imem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Instruction FIFO: push on kept ack, pop on transfer, full flush on taken jump
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (jump_taken) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                buf_instr[wr_ptr] <= imem_rdata;
                buf_pc[wr_ptr]    <= req_addr;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Outputs are all derived from registered state except the same-cycle redirect
    always_comb begin
        imem_req  = (state != IDLE);
        imem_addr = req_addr;
        id_valid  = (count != '0);
        id_instr  = buf_instr[rd_ptr];
        id_pc     = buf_pc[rd_ptr];
        id_opcode = id_instr[31:26];
        redirect  = jump_taken;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: imem responder, a jump-code driver standing in for the
// control unit, and a negedge checker that scores deliveries, fetch addresses and probes.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [15:0] id_pc;
    logic [1:0]  j;
    logic        br_cond;
    logic        redirect;

    instr_fetch_unit #(.AW(16), .DEPTH(2), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_opcode  (id_opcode),
        .id_pc      (id_pc),
        .j          (j),
        .br_cond    (br_cond),
        .redirect   (redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] instr;
        logic        red;
    } out_t;

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } probe_t;

    localparam int K_REQ     = 0;
    localparam int K_VALID   = 1;
    localparam int K_ADDR    = 2;
    localparam int K_PC      = 3;
    localparam int K_INSTR   = 4;
    localparam int K_RED     = 5;
    localparam int K_LEFT    = 6;
    localparam int K_TIMEOUT = 7;

    out_t        exp_out[$];
    logic [15:0] exp_addr[$];
    probe_t      probes[$];

    int n_cmp = 0;
    int n_bad = 0;

    // stimulus-side controls
    logic        jmp_arm;
    logic [15:0] jmp_pc;
    logic [1:0]  jmp_code;
    logic        jmp_cond;
    int          budget_total;
    logic [15:0] slow_addr;
    int          slow_delay;
    logic        stray_req;

    // responder-side state
    int   acks_given = 0;
    int   waited     = 0;
    logic stray_done = 1'b0;

    // memory contents: a few jump words, everything else a recognisable pattern
    function automatic logic [31:0] word_at(input logic [15:0] a);
        case (a)
            16'h0002: word_at = {6'b000010, 10'h000, 16'hFFFF};
            16'h0003: word_at = {6'b100010, 10'h000, 16'h0040};
            16'h0004: word_at = {6'b000010, 10'h000, 16'h0080};
            default:  word_at = {a[5:0], 10'h3C3, a};
        endcase
    endfunction

    function automatic string kind_name(input int k);
        case (k)
            K_REQ:   kind_name = "imem_req";
            K_VALID: kind_name = "id_valid";
            K_ADDR:  kind_name = "imem_addr";
            K_PC:    kind_name = "id_pc";
            K_INSTR: kind_name = "id_instr";
            K_RED:   kind_name = "redirect";
            K_LEFT:  kind_name = "leftover_expectations";
            default: kind_name = "drain_timeout";
        endcase
    endfunction

    // control-unit stand-in: jump code only for the armed head address
    always_comb begin
        j       = 2'b00;
        br_cond = jmp_cond;
        if (jmp_arm && id_valid && (id_pc == jmp_pc)) j = jmp_code;
    end

    // checker + imem responder, all on the falling edge
    always @(negedge clk) begin
        logic [31:0] act;
        out_t        e;
        logic [15:0] ea;
        int          dly;
        if (!rst) begin
            if (id_valid && id_ready) begin
                if (exp_out.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_transfer: got pc %h instr %h, required none", id_pc, id_instr);
                end else begin
                    e = exp_out.pop_front();
                    n_cmp++;
                    if (id_pc !== e.pc) begin n_bad++; $display("FAIL out_pc: got %h required %h", id_pc, e.pc); end
                    n_cmp++;
                    if (id_instr !== e.instr) begin n_bad++; $display("FAIL out_instr pc %h: got %h required %h", e.pc, id_instr, e.instr); end
                    n_cmp++;
                    if (id_opcode !== e.instr[31:26]) begin n_bad++; $display("FAIL out_opcode pc %h: got %b required %b", e.pc, id_opcode, e.instr[31:26]); end
                    n_cmp++;
                    if (redirect !== e.red) begin n_bad++; $display("FAIL out_redirect pc %h: got %b required %b", e.pc, redirect, e.red); end
                end
            end else begin
                n_cmp++;
                if (redirect !== 1'b0) begin n_bad++; $display("FAIL idle_redirect: got %b required 0", redirect); end
            end
        end

        if (rst) begin
            imem_ack = 1'b0;
            waited   = 0;
        end else if (!imem_req) begin
            imem_ack = 1'b0;
            if (stray_req && !stray_done) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEADBEEF;
                stray_done = 1'b1;
            end
            waited = 0;
        end else begin
            dly = (imem_addr == slow_addr) ? slow_delay : 0;
            if (acks_given < budget_total && waited >= dly) begin
                imem_ack   = 1'b1;
                imem_rdata = word_at(imem_addr);
                acks_given++;
                waited = 0;
                n_cmp++;
                if (exp_addr.size() == 0) begin
                    n_bad++;
                    $display("FAIL fetch_addr: got %h required no request", imem_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    if (imem_addr !== ea) begin n_bad++; $display("FAIL fetch_addr: got %h required %h", imem_addr, ea); end
                end
            end else begin
                imem_ack = 1'b0;
                waited++;
            end
        end

        while (probes.size() != 0) begin
            probe_t p;
            p = probes.pop_front();
            case (p.kind)
                K_REQ:   act = {31'd0, imem_req};
                K_VALID: act = {31'd0, id_valid};
                K_ADDR:  act = {16'd0, imem_addr};
                K_PC:    act = {16'd0, id_pc};
                K_INSTR: act = id_instr;
                K_RED:   act = {31'd0, redirect};
                K_LEFT: begin
                    act = exp_out.size() + exp_addr.size();
                    exp_out.delete();
                    exp_addr.delete();
                end
                default: act = 32'd1;
            endcase
            n_cmp++;
            if (act !== p.exp) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", kind_name(p.kind), act, p.exp);
            end
        end
    end

    task automatic probe(input int kind, input logic [31:0] expv);
        probe_t p;
        p.kind = kind;
        p.exp  = expv;
        probes.push_back(p);
    endtask

    task automatic push_addr(input logic [15:0] a);
        exp_addr.push_back(a);
    endtask

    task automatic push_out(input logic [15:0] a, input logic red);
        out_t e;
        e.pc    = a;
        e.instr = word_at(a);
        e.red   = red;
        exp_out.push_back(e);
    endtask

    task automatic push_seq(input int n);
        for (int i = 0; i < n; i++) begin
            push_addr(16'(i));
            push_out(16'(i), 1'b0);
        end
    endtask

    // reset with a fresh ack allowance; returns just after rst drops (next edge is the first active one)
    task automatic do_reset(input int nacks);
        @(posedge clk); #2;
        probe(K_LEFT, 32'd0);
        rst = 1'b1;
        budget_total = acks_given + nacks;
        repeat (2) @(posedge clk);
        #1;
        probe(K_REQ,   32'd0);
        probe(K_VALID, 32'd0);
        probe(K_PC,    32'd0);
        probe(K_INSTR, 32'd0);
        probe(K_RED,   32'd0);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_out.size() != 0 || exp_addr.size() != 0) && k < 80) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (k >= 80) probe(K_TIMEOUT, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        id_ready     = 1'b0;
        jmp_arm      = 1'b0;
        jmp_pc       = 16'h0000;
        jmp_code     = 2'b00;
        jmp_cond     = 1'b0;
        budget_total = 0;
        slow_addr    = 16'h1234;
        slow_delay   = 0;
        stray_req    = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'd0;

        // sequential fetch, ack in the request cycle, decode always ready
        id_ready = 1'b1;
        do_reset(6);
        push_seq(6);
        @(posedge clk); #1;
        probe(K_REQ, 32'd1);
        probe(K_VALID, 32'd0);
        probe(K_ADDR, 32'd0);
        @(posedge clk); #1;
        probe(K_VALID, 32'd1);
        probe(K_PC, 32'd0);
        drain();

        // decode stalled: two words buffered, fetch stops, then resumes in order
        id_ready = 1'b0;
        do_reset(5);
        push_seq(5);
        repeat (6) @(posedge clk);
        #1;
        probe(K_REQ, 32'd0);
        probe(K_VALID, 32'd1);
        probe(K_PC, 32'd0);
        #1 id_ready = 1'b1;
        drain();

        // jmp at pc 3 to 0x0040; the ack arriving with the jump is discarded
        jmp_arm = 1'b1; jmp_pc = 16'h0003; jmp_code = 2'b10; jmp_cond = 1'b0;
        do_reset(8);
        for (int i = 0; i < 5; i++) push_addr(16'(i));
        push_addr(16'h0040); push_addr(16'h0041); push_addr(16'h0042);
        push_out(16'h0000, 1'b0); push_out(16'h0001, 1'b0); push_out(16'h0002, 1'b0);
        push_out(16'h0003, 1'b1);
        push_out(16'h0040, 1'b0); push_out(16'h0041, 1'b0); push_out(16'h0042, 1'b0);
        drain();

        // jb not taken: plain sequential stream
        jmp_code = 2'b11; jmp_cond = 1'b0;
        do_reset(6);
        push_seq(6);
        drain();

        // jb taken
        jmp_cond = 1'b1;
        do_reset(8);
        for (int i = 0; i < 5; i++) push_addr(16'(i));
        push_addr(16'h0040); push_addr(16'h0041); push_addr(16'h0042);
        push_out(16'h0000, 1'b0); push_out(16'h0001, 1'b0); push_out(16'h0002, 1'b0);
        push_out(16'h0003, 1'b1);
        push_out(16'h0040, 1'b0); push_out(16'h0041, 1'b0); push_out(16'h0042, 1'b0);
        drain();

        // jmp at pc 4 while the request for 0x0005 waits three cycles for its ack
        jmp_pc = 16'h0004; jmp_code = 2'b10; jmp_cond = 1'b0;
        slow_addr = 16'h0005; slow_delay = 3;
        do_reset(9);
        for (int i = 0; i < 6; i++) push_addr(16'(i));
        push_addr(16'h0080); push_addr(16'h0081); push_addr(16'h0082);
        for (int i = 0; i < 4; i++) push_out(16'(i), 1'b0);
        push_out(16'h0004, 1'b1);
        push_out(16'h0080, 1'b0); push_out(16'h0081, 1'b0); push_out(16'h0082, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        probe(K_REQ, 32'd1);
        probe(K_ADDR, 32'h0005);
        probe(K_VALID, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        probe(K_REQ, 32'd0);
        drain();
        slow_addr = 16'h1234; slow_delay = 0;

        // jmp to 0xFFFF: pc wraps to 0x0000
        jmp_pc = 16'h0002; jmp_code = 2'b10;
        do_reset(7);
        push_addr(16'h0000); push_addr(16'h0001); push_addr(16'h0002); push_addr(16'h0003);
        push_addr(16'hFFFF); push_addr(16'h0000); push_addr(16'h0001);
        push_out(16'h0000, 1'b0); push_out(16'h0001, 1'b0); push_out(16'h0002, 1'b1);
        push_out(16'hFFFF, 1'b0); push_out(16'h0000, 1'b0); push_out(16'h0001, 1'b0);
        drain();
        probe(K_REQ, 32'd1);
        probe(K_ADDR, 32'h0002);

        // reset while a request is outstanding, then a stray ack before any request
        jmp_arm = 1'b0;
        @(posedge clk); #2;
        probe(K_LEFT, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        probe(K_REQ, 32'd0);
        probe(K_VALID, 32'd0);
        stray_req = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        probe(K_VALID, 32'd0);
        probe(K_REQ, 32'd1);
        probe(K_ADDR, 32'h0000);

        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
